// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LFSR burst scheduler.
// Imported by the LFSR step register and the arbiter top.
package lfsr_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hD008;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

  // x^16+x^15+x^13+x^4+1, left shift, feedback into bit 0
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] v
  );
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] seed_fix(
    input logic [15:0] s
  );
    return (s == 16'h0000) ? LFSR_SEED : s;
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// 16-bit LFSR register with seed load and step enable.
// A zero seed is replaced so the lock-up state is unreachable.
module lfsr16_step
  import lfsr_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        en_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = seed_fix(seed_i);
    end else if (en_i) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lfsr_burst_arbiter.sv
// Round-robin burst scheduler sharing one LFSR pattern source.
// Words advance the generator only when accepted by the grantee.
module lfsr_burst_arbiter
  import lfsr_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] rdy_i,
  input  logic            seed_we_i,
  input  logic [15:0]     seed_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o,
  output logic [15:0]     data_o,
  output logic            last_o,
  output logic            busy_o
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(NREQ - 1);
  localparam logic          ONE_WORD = (BURST_LEN == 1);
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            pend_q, pend_d;
  logic [15:0]     pseed_q, pseed_d;

  logic            found;
  logic [PW-1:0]   pick;
  logic            xfer;
  logic            load;
  logic [15:0]     load_val;
  logic [CW-1:0]   cnt_inc;
  int              k;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req_i[k]) begin
        found = 1'b1;
        pick  = PW'(k);
      end
    end
  end

  assign xfer     = valid_q & |(gnt_q & rdy_i);
  assign load     = (state_q == IDLE) & (seed_we_i | pend_q);
  assign load_val = seed_we_i ? seed_i : pseed_q;
  assign cnt_inc  = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!load && found) state_d = BURST;
      BURST: if (xfer && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE) | pend_q;
  end

  always_comb begin
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    pend_d  = pend_q;
    pseed_d = pseed_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          pend_d = 1'b0;
        end else if (found) begin
          gnt_d   = GNT_ONE << pick;
          gidx_d  = pick;
          cnt_d   = '0;
          valid_d = 1'b1;
          last_d  = ONE_WORD;
        end
      end
      BURST: begin
        // seed writes are parked until the burst drains
        if (seed_we_i) begin
          pend_d  = 1'b1;
          pseed_d = seed_i;
        end
        if (xfer) begin
          cnt_d = cnt_inc;
          if (last_q) begin
            gnt_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            ptr_d   = (gidx_q == PTR_MAX) ? '0 : gidx_q + 1'b1;
          end else begin
            last_d = (cnt_inc == CNT_LAST);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      pseed_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      pseed_q <= pseed_d;
    end
  end

  lfsr16_step u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .seed_i (load_val),
    .en_i   (xfer),
    .q_o    (data_o)
  );

  assign gnt_o   = gnt_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Directed vector bench for lfsr_burst_arbiter (NREQ=4, BURST_LEN=4).
// Each row drives inputs before an edge and checks outputs after it.
module tb_lfsr_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, rdy;
  logic        swe;
  logic [15:0] seed;
  logic [3:0]  gnt;
  logic        vld;
  logic [15:0] dat;
  logic        lst;
  logic        bsy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rdy;
    logic        swe;
    logic [15:0] seed;
    logic [3:0]  gnt;
    logic        vld;
    logic [15:0] dat;
    logic        lst;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  lfsr_burst_arbiter #(
    .NREQ      (4),
    .BURST_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .rdy_i     (rdy),
    .seed_we_i (swe),
    .seed_i    (seed),
    .gnt_o     (gnt),
    .valid_o   (vld),
    .data_o    (dat),
    .last_o    (lst),
    .busy_o    (bsy)
  );

  task automatic chk(
    input string       nm,
    input int          idx,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic add(
    input logic [3:0]  rq,
    input logic [3:0]  rd,
    input logic        we,
    input logic [15:0] sd,
    input logic [3:0]  g,
    input logic        v,
    input logic [15:0] d,
    input logic        l,
    input logic        b
  );
    vec_t t;
    t.req = rq; t.rdy = rd;
    t.swe = we; t.seed = sd;
    t.gnt = g;  t.vld = v;
    t.dat = d;  t.lst = l;
    t.bsy = b;
    tbl.push_back(t);
  endtask

  task automatic chk_out(
    input string       tag,
    input int          idx,
    input logic [3:0]  g,
    input logic        v,
    input logic [15:0] d,
    input logic        l,
    input logic        b
  );
    chk({tag, ".gnt"}, idx, 16'(gnt), 16'(g));
    chk({tag, ".valid"}, idx, 16'(vld), 16'(v));
    chk({tag, ".data"}, idx, dat, d);
    chk({tag, ".last"}, idx, 16'(lst), 16'(l));
    chk({tag, ".busy"}, idx, 16'(bsy), 16'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; rdy = '0;
    swe = 1'b0; seed = '0;

    // burst to req0 from reset seed
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0001, 0, 1);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0002, 0, 1);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0004, 0, 1);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0008, 1, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h0, 0, 16'h0011, 0, 0);
    // all requesting: round robin 1, 2, 3, 0
    add(4'hF, 4'hF, 0, 16'h0, 4'h2, 1, 16'h0011, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h2, 1, 16'h0022, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h2, 1, 16'h0044, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h2, 1, 16'h0088, 1, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h0, 0, 16'h0111, 0, 0);
    // requester 2 stalls 3 cycles, then once on the last word
    add(4'hF, 4'hF, 0, 16'h0, 4'h4, 1, 16'h0111, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h4, 1, 16'h0222, 0, 1);
    add(4'hF, 4'hB, 0, 16'h0, 4'h4, 1, 16'h0222, 0, 1);
    add(4'hF, 4'hB, 0, 16'h0, 4'h4, 1, 16'h0222, 0, 1);
    add(4'hF, 4'hB, 0, 16'h0, 4'h4, 1, 16'h0222, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h4, 1, 16'h0444, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h4, 1, 16'h0888, 1, 1);
    add(4'hF, 4'hB, 0, 16'h0, 4'h4, 1, 16'h0888, 1, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h0, 0, 16'h1111, 0, 0);
    add(4'hF, 4'hF, 0, 16'h0, 4'h8, 1, 16'h1111, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h8, 1, 16'h2223, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h8, 1, 16'h4446, 0, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h8, 1, 16'h888D, 1, 1);
    add(4'hF, 4'hF, 0, 16'h0, 4'h0, 0, 16'h111A, 0, 0);
    // requester 0, drops REQ mid-burst
    add(4'hF, 4'hF, 0, 16'h0, 4'h1, 1, 16'h111A, 0, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h1, 1, 16'h2234, 0, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h1, 1, 16'h4468, 0, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h1, 1, 16'h88D0, 1, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h0, 0, 16'h11A1, 0, 0);
    add(4'h0, 4'hF, 0, 16'h0, 4'h0, 0, 16'h11A1, 0, 0);
    // seed 0x8000 in IDLE
    add(4'h0, 4'hF, 1, 16'h8000, 4'h0, 0, 16'h8000, 0, 0);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h8000, 0, 1);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0001, 0, 1);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0002, 0, 1);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0004, 1, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h0, 0, 16'h0008, 0, 0);
    // zero seed with REQ: arbitration deferred
    add(4'h1, 4'hF, 1, 16'h0000, 4'h0, 0, 16'h0001, 0, 0);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0001, 0, 1);
    // seed writes mid-burst, last one wins
    add(4'h0, 4'hF, 1, 16'h1234, 4'h1, 1, 16'h0002, 0, 1);
    add(4'h0, 4'hF, 1, 16'h8000, 4'h1, 1, 16'h0004, 0, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0008, 1, 1);
    add(4'h1, 4'hF, 0, 16'h0, 4'h0, 0, 16'h0011, 0, 1);
    add(4'h1, 4'hF, 0, 16'h0, 4'h0, 0, 16'h8000, 0, 0);
    add(4'h1, 4'hF, 0, 16'h0, 4'h1, 1, 16'h8000, 0, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0001, 0, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0002, 0, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h1, 1, 16'h0004, 1, 1);
    add(4'h0, 4'hF, 0, 16'h0, 4'h0, 0, 16'h0008, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", 0, 4'h0, 0, 16'h0001, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req  = tbl[i].req;
      rdy  = tbl[i].rdy;
      swe  = tbl[i].swe;
      seed = tbl[i].seed;
      step();
      chk_out("vec", i, tbl[i].gnt, tbl[i].vld,
              tbl[i].dat, tbl[i].lst, tbl[i].bsy);
    end

    // reset mid-burst with a pending seed; pointer is 1 here
    req = 4'h3; rdy = 4'hF;
    swe = 1'b0; seed = '0;
    step();
    chk_out("mrst_g", 0, 4'h2, 1, 16'h0008, 0, 1);
    swe = 1'b1; seed = 16'h8000;
    step();
    chk_out("mrst_w2", 0, 4'h2, 1, 16'h0011, 0, 1);
    swe = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("mrst_async", 0, 4'h0, 0, 16'h0001, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("mrst_after", 0, 4'h1, 1, 16'h0001, 0, 1);
    step();
    chk_out("mrst_after", 1, 4'h1, 1, 16'h0002, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_burst_arbiter.md
# lfsr_burst_arbiter

Round-robin scheduler that shares one 16-bit pseudo-random pattern generator (x^16+x^15+x^13+x^4+1, left-shift, seed 0x0001) among `NREQ` memory-test requesters. A granted requester receives a fixed-length burst of consecutive LFSR words under a valid/ready handshake. The generator advances only on accepted words, so each requester sees a contiguous slice of one global sequence. The seed can be reloaded at runtime. The block sits between the memory-controller test engines and the pattern source.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `BURST_LEN`, 4: words per grant, 1..256.
- `CLK` in 1: single clock, rising edge.
- `RSTN` in 1: reset, asynchronous, active-low.
- `REQ` in NREQ: per-requester burst request, level.
- `RDY` in NREQ: per-requester word accept; only the granted bit is sampled.
- `SEED_WE` in 1: seed write strobe, one cycle.
- `SEED` in 16: seed value, sampled with `SEED_WE`.
- `GNT` out NREQ: one-hot grant, held for the whole burst.
- `VALID` out 1: `DATA` is valid for the granted requester.
- `DATA` out 16: current LFSR word.
- `LAST` out 1: the current word is the final word of the burst.
- `BUSY` out 1: state is not IDLE, or a seed write is pending.

## Operation
- **Reset values:** state IDLE, LFSR 0x0001, `GNT`=0, `VALID`=0, `LAST`=0, `BUSY`=0, RR pointer 0, word count 0, pending-seed flag 0.
- **LFSR step:** `next = {lfsr[14:0], lfsr[15]^lfsr[14]^lfsr[12]^lfsr[3]}`.
- **Seed loads:** a zero seed loads 0x0001. The all-zero state is never reachable.
- **IDLE state:**
  - If `SEED_WE` is high or the pending flag is set, load the seed and stay in IDLE; no arbitration that cycle. A direct `SEED_WE` wins over the pending value.
  - Otherwise, if `|REQ`, select the first set `REQ` bit searching upward from the pointer, with wrap. Register `GNT` one-hot, clear the count, and go to BURST.
- **BURST state:**
  - `VALID`=1 and `DATA`=LFSR.
  - A transfer occurs when `VALID & RDY[g]`. On each transfer the LFSR steps and the count increments.
  - `LAST`=1 while count == `BURST_LEN`-1.
- **End of burst:** a transfer with `LAST`=1 clears `GNT`, `VALID` and `LAST`, sets pointer = g+1 (wrapping NREQ-1 to 0), and returns to IDLE.
- **REQ during a burst:** `REQ[g]` deasserting mid-burst is ignored; the burst always completes. Other `REQ` bits are ignored until IDLE.
- **SEED_WE during a burst:** latches `SEED` into the pending register; the last write wins. The value is applied in the first IDLE cycle. The LFSR is never changed mid-burst.
- **Width rules:** count width is clog2(`BURST_LEN`), minimum 1. When `BURST_LEN`=1, `LAST` is high for the single word.

## Timing
- **Grant latency:** `REQ` seen in IDLE at edge t gives `GNT`/`VALID`/`DATA` valid after edge t, with no combinational path from `REQ` to outputs.
- **Throughput:** one word per cycle while `RDY[g]`=1. `DATA` is stable while stalled.
- **Turnaround:** the final transfer at edge t puts the block in IDLE after t. The earliest next grant is after t+1, giving one idle cycle between bursts.
- **Seed in IDLE:** a seed write costs one IDLE cycle, and arbitration is deferred by one cycle.
- **Reset mid-burst:** all outputs drop immediately (asynchronous) to their reset values. The pending seed is discarded.
- **Registered outputs:** all outputs are registered, except `BUSY`, which is a combinational OR of state and pending flag.

## Structure
- **Shared package `lfsr_sched_pkg`:**
  - state enum: IDLE, BURST
  - tap constant 16'hD008
  - reset seed 16'h0001
- **Sub-module `lfsr16_step`:**
  - load/enable LFSR register, with zero-seed substitution
  - instantiated once
- **Top-level contents:** the arbiter, counter and pending-seed logic stay in the top level.

## Test plan
- **Reset sequence:** after reset, `REQ`=0001 with `RDY`=1111 and `BURST_LEN`=4 → `GNT`=0001, `DATA` 0x0001, 0x0002, 0x0004, 0x0008, `LAST` on the 4th word. The next burst starts at 0x0011.
- **Round robin:** `REQ`=1111 held → grant order 0, 1, 2, 3, 0. Exactly one idle cycle between bursts; `DATA` continues the sequence without a gap.
- **Stall:** `RDY[g]` low for 3 cycles mid-burst → `DATA`, `LAST` and count are frozen, and the LFSR does not step.
- **Seed:** `SEED`=0x8000 in IDLE → first word 0x8000, next 0x0001. `SEED`=0x0000 → first word 0x0001. `SEED_WE` mid-burst → the burst is unaffected, `BUSY` stays high for one extra IDLE cycle, and the following burst starts at the new seed.
- **Reset mid-burst:** `RSTN` low during word 2 → `GNT`/`VALID`/`LAST` are 0 immediately. After release the pointer is 0 and `DATA` restarts at 0x0001.
- **Mid-burst REQ drop:** `REQ[g]` dropped mid-burst → all `BURST_LEN` words are still delivered.
